// File: rtl/lagarto_fpu_pkg.sv
// Shared single-precision FPU types: operand layout, classifier result, fclass mask, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lagarto_fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mnt;
  } sfp_encoding_t;

  typedef enum logic [3:0] {
    FP_NEG_INF,
    FP_NEG_NORM,
    FP_NEG_SUBNORM,
    FP_NEG_ZERO,
    FP_POS_ZERO,
    FP_POS_SUBNORM,
    FP_POS_NORM,
    FP_POS_INF,
    FP_SNAN,
    FP_QNAN
  } fp_class_t;

  typedef logic [9:0] fclass_mask_t;

  // Bit positions of the RISC-V fclass result.
  localparam int unsigned FCLASS_NEG_INF     = 0;
  localparam int unsigned FCLASS_NEG_NORM    = 1;
  localparam int unsigned FCLASS_NEG_SUBNORM = 2;
  localparam int unsigned FCLASS_NEG_ZERO    = 3;
  localparam int unsigned FCLASS_POS_ZERO    = 4;
  localparam int unsigned FCLASS_POS_SUBNORM = 5;
  localparam int unsigned FCLASS_POS_NORM    = 6;
  localparam int unsigned FCLASS_POS_INF     = 7;
  localparam int unsigned FCLASS_SNAN        = 8;
  localparam int unsigned FCLASS_QNAN        = 9;

  typedef enum logic [1:0] {
    VFC_IDLE,
    VFC_RUN,
    VFC_DRAIN
  } vfclass_state_t;

endpackage

// File: rtl/vfclass_sfp_unit_classify.sv
// Single-precision classifier: maps an operand to its fp_class_t category.
// Latency: purely combinational.
// Backpressure: none, no state.
module vfclass_sfp_unit_classify
  import lagarto_fpu_pkg::*;
(
  input  sfp_encoding_t i_op,
  output fp_class_t     o_class
);

  // Decode exponent extremes first, then split by sign.
  always_comb begin
    o_class = FP_POS_ZERO;
    if (i_op.exp == 8'hFF) begin
      if (i_op.mnt == 23'd0) begin
        o_class = i_op.sign ? FP_NEG_INF : FP_POS_INF;
      end else begin
        o_class = i_op.mnt[22] ? FP_QNAN : FP_SNAN;
      end
    end else if (i_op.exp == 8'h00) begin
      if (i_op.mnt == 23'd0) begin
        o_class = i_op.sign ? FP_NEG_ZERO : FP_POS_ZERO;
      end else begin
        o_class = i_op.sign ? FP_NEG_SUBNORM : FP_POS_SUBNORM;
      end
    end else begin
      o_class = i_op.sign ? FP_NEG_NORM : FP_POS_NORM;
    end
  end

endmodule

// File: rtl/vfclass_sfp_unit.sv
// Vector fclass for single precision: classifies vl operands and streams out 10-bit class masks.
// Latency: 2 cycles from operand accept to res_valid_o; done_o one cycle after the last result handshake.
// Backpressure: two-stage valid/ready pipe; op_ready_o drops combinationally when res_ready_i is low and both stages are full.
module vfclass_sfp_unit
  import lagarto_fpu_pkg::*;
#(
  parameter int VL_WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rsn_i,
  input  logic                start_i,
  input  logic [VL_WIDTH-1:0] vl_i,
  input  logic                flush_i,
  input  logic                op_valid_i,
  output logic                op_ready_o,
  input  logic [31:0]         op_data_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [31:0]         res_data_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam logic [VL_WIDTH-1:0] CNT_ONE = {{(VL_WIDTH-1){1'b0}}, 1'b1};

  vfclass_state_t      r_state, w_state_nxt;
  logic [VL_WIDTH-1:0] r_vl, r_acc_cnt, w_acc_inc;
  logic                r_s1_vld, r_s2_vld, r_done;
  sfp_encoding_t       r_s1_dat;
  fclass_mask_t        r_s2_dat, w_mask;
  fp_class_t           w_class;
  logic                w_s1_load, w_s2_load, w_accept, w_pipe_empty_nxt, w_done_nxt;

  // NaNs are split by the quiet bit of the operand itself, ignoring the classifier's NaN subtype and sign.
  function automatic fclass_mask_t to_mask(input fp_class_t c, input logic quiet);
    fclass_mask_t m;
    m = '0;
    case (c)
      FP_NEG_INF:       m[FCLASS_NEG_INF]     = 1'b1;
      FP_NEG_NORM:      m[FCLASS_NEG_NORM]    = 1'b1;
      FP_NEG_SUBNORM:   m[FCLASS_NEG_SUBNORM] = 1'b1;
      FP_NEG_ZERO:      m[FCLASS_NEG_ZERO]    = 1'b1;
      FP_POS_ZERO:      m[FCLASS_POS_ZERO]    = 1'b1;
      FP_POS_SUBNORM:   m[FCLASS_POS_SUBNORM] = 1'b1;
      FP_POS_NORM:      m[FCLASS_POS_NORM]    = 1'b1;
      FP_POS_INF:       m[FCLASS_POS_INF]     = 1'b1;
      FP_SNAN, FP_QNAN: m[quiet ? FCLASS_QNAN : FCLASS_SNAN] = 1'b1;
      default:          m = '0;
    endcase
    return m;
  endfunction

  vfclass_sfp_unit_classify u_classify (
    .i_op    (r_s1_dat),
    .o_class (w_class)
  );

  assign w_mask    = to_mask(w_class, r_s1_dat.mnt[22]);
  assign w_s2_load = !r_s2_vld || res_ready_i;
  assign w_s1_load = !r_s1_vld || w_s2_load;
  assign w_acc_inc = r_acc_cnt + CNT_ONE;

  // Ready only while operands remain and stage 1 has room; res_ready_i is the only combinational input path.
  assign op_ready_o = (r_state == VFC_RUN) && (r_acc_cnt < r_vl) && w_s1_load;
  assign w_accept   = op_valid_i && op_ready_o;

  // In DRAIN nothing is accepted, so the pipe is empty next cycle once every held result has moved out.
  assign w_pipe_empty_nxt = (!r_s1_vld || w_s1_load) && (w_s2_load ? !r_s1_vld : !r_s2_vld);

  // Next-state logic for the instruction sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      VFC_IDLE: begin
        if (start_i) begin
          w_state_nxt = (vl_i == '0) ? VFC_DRAIN : VFC_RUN;
        end
      end
      VFC_RUN: begin
        if (w_accept && (w_acc_inc == r_vl)) begin
          w_state_nxt = VFC_DRAIN;
        end
      end
      VFC_DRAIN: begin
        if (w_pipe_empty_nxt) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = VFC_IDLE;
        end
      end
      default: w_state_nxt = VFC_IDLE;
    endcase
  end

  // Control state: flush and reset both drop everything in flight and return to IDLE.
  always_ff @(posedge clk_i) begin
    if (!rsn_i || flush_i) begin
      r_state   <= VFC_IDLE;
      r_acc_cnt <= '0;
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (r_state == VFC_IDLE && start_i) begin
        r_acc_cnt <= '0;
      end else if (w_accept) begin
        r_acc_cnt <= w_acc_inc;
      end
      if (w_s1_load) r_s1_vld <= w_accept;
      if (w_s2_load) r_s2_vld <= r_s1_vld;
    end
  end

  // Data registers: only reset clears them; they load on real transfers so stalled outputs hold.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      r_vl     <= '0;
      r_s1_dat <= '0;
      r_s2_dat <= '0;
    end else begin
      if (!flush_i && r_state == VFC_IDLE && start_i) r_vl <= vl_i;
      if (w_s1_load && w_accept) r_s1_dat <= op_data_i;
      if (w_s2_load && r_s1_vld) r_s2_dat <= w_mask;
    end
  end

  assign res_valid_o = r_s2_vld;
  assign res_data_o  = {22'd0, r_s2_dat};
  assign busy_o      = (r_state != VFC_IDLE);
  assign done_o      = r_done;

endmodule

// File: tb/tb_vfclass_sfp_unit.sv
// Scoreboard bench for vfclass_sfp_unit: random operands vs. a bit-pattern classification model.
// Latency: checks exact 2-cycle accept-to-result latency when downstream never stalls.
// Backpressure: exercises toggling and random res_ready_i, flush and mid-run reset.
module tb_vfclass_sfp_unit;

  logic        clk = 1'b0;
  logic        rsn_i, start_i, flush_i, op_valid_i, res_ready_i;
  logic [7:0]  vl_i;
  logic [31:0] op_data_i;
  logic        op_ready_o, res_valid_o, busy_o, done_o;
  logic [31:0] res_data_o;

  always #5 clk = ~clk;

  vfclass_sfp_unit #(.VL_WIDTH(8)) dut (
    .clk_i       (clk),
    .rsn_i       (rsn_i),
    .start_i     (start_i),
    .vl_i        (vl_i),
    .flush_i     (flush_i),
    .op_valid_i  (op_valid_i),
    .op_ready_o  (op_ready_o),
    .op_data_i   (op_data_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_data_o  (res_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  typedef struct {
    logic [9:0] mask;
    int         cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  logic [31:0] op_src[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc_cnt = 0;
  int          n_acc = 0;
  int          n_done = 0;
  int          last_pop_cyc = 0;
  bit          lat_exact = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_dat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // fclass from the raw bit pattern: magnitude ordering of IEEE encodings.
  function automatic logic [9:0] ref_mask(input logic [31:0] x);
    logic [31:0] a;
    int          idx;
    logic [9:0]  m;
    a = x & 32'h7FFF_FFFF;
    if (a > 32'h7F80_0000)       idx = (a >= 32'h7FC0_0000) ? 9 : 8;
    else if (a == 32'h7F80_0000) idx = x[31] ? 0 : 7;
    else if (a >= 32'h0080_0000) idx = x[31] ? 1 : 6;
    else if (a != 0)             idx = x[31] ? 2 : 5;
    else                         idx = x[31] ? 3 : 4;
    m = 10'd1;
    return m << idx;
  endfunction

  function automatic logic [31:0] rand_op();
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      default: e = 8'($urandom_range(1, 254));
    endcase
    case ($urandom_range(0, 2))
      0:       m = 23'd0;
      default: m = 23'($urandom);
    endcase
    return {s, e, m};
  endfunction

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Input side: every accepted operand pushes its expected mask and accept cycle.
  always @(negedge clk) begin
    if (rsn_i && !flush_i) begin
      if (sb_q.size() >= 2 && !res_ready_i) check("op_ready_when_full", 32'(op_ready_o), 32'd0);
      if (op_valid_i && op_ready_o) begin
        sb_q.push_back('{ref_mask(op_data_i), cyc_cnt});
        n_acc++;
      end
    end
    if (done_o) n_done++;
  end

  // Output side: pop on each handshake, verify data, latency and stall stability.
  always @(negedge clk) begin
    #1;
    if (prev_stall) begin
      check("stall_hold_valid", 32'(res_valid_o), 32'd1);
      check("stall_hold_data", res_data_o, prev_dat);
    end
    if (res_valid_o && res_ready_i) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got 0x%0h with nothing outstanding", res_data_o);
      end else begin
        sb_e = sb_q.pop_front();
        check("res_data", res_data_o, {22'd0, sb_e.mask});
        if (lat_exact) check("latency", 32'(cyc_cnt - sb_e.cyc), 32'd2);
        last_pop_cyc = cyc_cnt;
      end
    end
    prev_stall = res_valid_o && !res_ready_i && rsn_i && !flush_i;
    prev_dat   = res_data_o;
    if (!rsn_i || flush_i) sb_q.delete();
  end

  // rmode: 0 ready high, 1 pattern 1,0,0,1, 2 random. flush_after<0 disables flush.
  task automatic run(input int vl, input int rmode, input int flush_after, input bit extra_start,
                     output int done_rel, output int accepts);
    int idx = 0;
    int cyc = 0;
    bit fl = 1'b0;
    bit flushed = 1'b0;
    n_acc     = 0;
    done_rel  = -1;
    lat_exact = (rmode == 0);
    @(posedge clk); #1;
    start_i = 1'b1; vl_i = 8'(vl); op_valid_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("busy_after_start", 32'(busy_o), 32'd1);
    check("no_early_done", 32'(done_o), 32'd0);
    while (cyc < 300) begin
      fl = (flush_after >= 0) && (n_acc >= flush_after);
      flush_i    = fl;
      op_valid_i = !fl && (idx < op_src.size()) && ($urandom_range(0, 3) != 0);
      op_data_i  = (idx < op_src.size()) ? op_src[idx] : 32'h0;
      case (rmode)
        0:       res_ready_i = 1'b1;
        1:       res_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: res_ready_i = 1'($urandom_range(0, 1));
      endcase
      start_i = extra_start && (cyc == 2);
      vl_i    = 8'd7;
      @(negedge clk);
      if (op_valid_i && op_ready_o) idx++;
      @(posedge clk); #1;
      cyc++;
      if (fl) begin
        flushed = 1'b1;
        break;
      end
      if (done_o) begin
        done_rel = cyc + 1;
        break;
      end
    end
    if (!flushed && done_rel < 0) begin
      checks++;
      failures++;
      $display("FAIL run_timeout: no done_o within 300 cycles (vl=%0d)", vl);
    end
    flush_i = 1'b0; op_valid_i = 1'b0; start_i = 1'b0; res_ready_i = 1'b1;
    accepts = n_acc;
  endtask

  task automatic post_run(input int vl, input int done_rel, input int acc, input int nd0);
    check("accept_count", 32'(acc), 32'(vl));
    check("done_seen", 32'(done_rel >= 0), 32'd1);
    check("busy_falls_with_done", 32'(busy_o), 32'd0);
    if (vl == 0) check("done_at_start_plus2", 32'(done_rel), 32'd2);
    else check("done_after_last_result", 32'(cyc_cnt - last_pop_cyc), 32'd1);
    @(posedge clk); #1;
    check("done_single_pulse", 32'(done_o), 32'd0);
    check("done_count", 32'(n_done - nd0), 32'd1);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_op_ready"}, 32'(op_ready_o), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid_o), 32'd0);
    check({tag, "_res_data"}, res_data_o, 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    int drel, acc, nd0, vl;
    rsn_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_valid_i = 1'b0;
    res_ready_i = 1'b1; vl_i = '0; op_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rsn_i = 1'b1;

    // Signed specials, one extra operand offered, start while busy ignored.
    op_src = '{32'hFF80_0000, 32'h8000_0001, 32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000};
    nd0 = n_done;
    run(4, 0, -1, 1'b1, drel, acc);
    post_run(4, drel, acc, nd0);

    // NaNs: quiet bit decides, sign ignored.
    op_src = '{32'h7FC0_0000, 32'hFFC0_0000, 32'h7F80_0001, 32'hFF80_0001};
    nd0 = n_done;
    run(4, 0, -1, 1'b0, drel, acc);
    post_run(4, drel, acc, nd0);

    // Toggling backpressure.
    op_src.delete();
    repeat (9) op_src.push_back(rand_op());
    nd0 = n_done;
    run(8, 1, -1, 1'b0, drel, acc);
    post_run(8, drel, acc, nd0);

    // Empty instruction.
    nd0 = n_done;
    run(0, 0, -1, 1'b0, drel, acc);
    post_run(0, drel, acc, nd0);

    // Flush after three of six accepts, then a clean restart.
    op_src.delete();
    repeat (6) op_src.push_back(rand_op());
    nd0 = n_done;
    run(6, 2, 3, 1'b0, drel, acc);
    check("flush_res_valid", 32'(res_valid_o), 32'd0);
    check("flush_busy", 32'(busy_o), 32'd0);
    check("flush_op_ready", 32'(op_ready_o), 32'd0);
    @(posedge clk); #1;
    check("flush_no_done", 32'(n_done - nd0), 32'd0);
    op_src.delete();
    repeat (5) op_src.push_back(rand_op());
    nd0 = n_done;
    run(5, 2, -1, 1'b0, drel, acc);
    post_run(5, drel, acc, nd0);

    // Reset mid-run with the pipe full under backpressure.
    @(posedge clk); #1;
    start_i = 1'b1; vl_i = 8'd10;
    @(posedge clk); #1;
    start_i = 1'b0; res_ready_i = 1'b0; op_valid_i = 1'b1;
    repeat (4) begin
      op_data_i = rand_op();
      @(posedge clk); #1;
    end
    rsn_i = 1'b0; op_valid_i = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("midrun_reset");
    rsn_i = 1'b1; res_ready_i = 1'b1;

    // Random instructions with random backpressure.
    for (int r = 0; r < 5; r++) begin
      vl = $urandom_range(1, 20);
      op_src.delete();
      repeat (vl + 2) op_src.push_back(rand_op());
      nd0 = n_done;
      run(vl, 2, -1, 1'b0, drel, acc);
      post_run(vl, drel, acc, nd0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vfclass_sfp_unit.md
# vfclass_sfp_unit

Vector floating-point classify unit for single-precision elements: accepts a stream of `vl` 32-bit operands and returns one RISC-V `fclass` result per element. Sits in the scalar floating-point unit group of the vector FPU, between the operand read path and lane writeback. Wraps one instance of the single-precision classifier, converts its `fp_class_t` output into the 10-bit RISC-V class mask, and adds element counting, a two-stage valid/ready pipeline and completion signalling.

## Interface
- `VL_WIDTH`, default 8: width of the element-count input.
- `clk_i`  in  1  clock; all logic is rising-edge.
- `rsn_i`  in  1  reset; synchronous, active-low.
- `start_i`  in  1  begin an instruction; sampled only in IDLE.
- `vl_i`  in  `VL_WIDTH`  number of elements; latched on an accepted `start_i`.
- `flush_i`  in  1  synchronous abort; higher priority than every input except reset.
- `op_valid_i`  in  1  operand valid.
- `op_ready_o`  out  1  operand accepted when both valid and ready are high.
- `op_data_i`  in  32  operand, `sfp_encoding_t` layout (sign, exp[7:0], mnt[22:0]).
- `res_valid_o`  out  1  result valid.
- `res_ready_i`  in  1  downstream ready.
- `res_data_o`  out  32  class mask in bits [9:0], bits [31:10] zero.
- `busy_o`  out  1  high in any state other than IDLE.
- `done_o`  out  1  one-cycle pulse after the last result is consumed.

## Operation
- FSM has three states: IDLE, RUN and DRAIN.
  - IDLE + `start_i`: latch `vl_i`, clear the accepted counter `acc_cnt`, go to RUN. If `vl_i`=0, go to DRAIN instead.
  - RUN: `op_ready_o` = (`acc_cnt` < `vl`) && stage-1 can advance. `acc_cnt` increments on each accept. When an accept makes `acc_cnt` == `vl`, go to DRAIN.
  - DRAIN: `op_ready_o` = 0. When both stages are empty, pulse `done_o` and go to IDLE.
- `start_i` outside IDLE is ignored.
- `op_valid_i` in IDLE or DRAIN is ignored and never accepted.
- Stage 1 holds a register with the operand and its valid bit. The classifier instance runs combinationally on the stage-1 register.
- Stage 2 holds a register with the 10-bit mask and its valid bit. It drives `res_*`.
- Mask mapping, one-hot:
  - bit0 = −inf, bit1 = −normal, bit2 = −subnormal, bit3 = −0
  - bit4 = +0, bit5 = +subnormal, bit6 = +normal, bit7 = +inf
  - bit8 = sNaN, bit9 = qNaN
- NaN rule: whenever the class is any NaN, the unit decides quiet versus signaling from `mnt[22]` of the stage-1 operand (1 = qNaN). The NaN sub-encoding in `fp_class_t` is not used for this decision, and the NaN sign is ignored.
- Pipeline advance:
  - stage 2 loads when it is empty or `res_ready_i` is high;
  - stage 1 loads when it is empty or stage 2 loads.
- `res_valid_o` and `res_data_o` hold stable while `res_valid_o && !res_ready_i`.
- `flush_i`: clears both valid bits and `acc_cnt` and returns to IDLE. No `done_o` is produced, and in-flight results are dropped.
- Reset behaves identically to flush and also zeroes the data registers.
- Reset values: `op_ready_o`=0, `res_valid_o`=0, `res_data_o`=0, `busy_o`=0, `done_o`=0, FSM in IDLE.

## Timing
- `start_i` at cycle T: `busy_o`=1 and `op_ready_o` may assert at T+1.
- Latency: an operand accepted at cycle T gives `res_valid_o` at T+2, provided no backpressure.
- Throughput is one element per cycle with `res_ready_i` held high. There are no bubbles between back-to-back accepts.
- Backpressure: with `res_ready_i` low, both stages fill and `op_ready_o` drops in the same cycle stage 1 would overflow.
  - `op_ready_o` depends combinationally on `res_ready_i`, and only through that path.
- `done_o` is asserted in the cycle after the final result handshake, registered from DRAIN-with-empty-pipe.
  - For `vl`=0, `done_o` is asserted at T+2 after `start_i`.
- A simultaneous final accept and a handshake on earlier results are both honoured in the same cycle.
- `flush_i` coincident with `start_i`: flush wins and the FSM stays in IDLE.

## Structure
- `lagarto_fpu_pkg` gains:
  - `fclass_mask_t` (logic [9:0]);
  - bit-index constants `FCLASS_NEG_INF` … `FCLASS_QNAN`;
  - the FSM state enum `vfclass_state_t`.
- Sub-module: one instance of the existing single-precision classifier. Mask conversion is a local function.
- Estimated size: about 180 lines of RTL.

## Test plan
- `vl`=4, operands 0xFF800000, 0x80000001, 0x00000000, 0x3F800000, `res_ready_i`=1 → masks 0x001, 0x004, 0x010, 0x040 at accept+2. `done_o` pulses once; `busy_o` falls with it.
- NaNs 0x7FC00000, 0xFFC00000, 0x7F800001, 0xFF800001 → 0x200, 0x200, 0x100, 0x100, regardless of sign.
- `vl`=8 with `res_ready_i` toggling 1,0,0,1 → no result lost or duplicated, data stable while stalled, `op_ready_o` low once both stages are full.
- `vl`=0 → no operand accepted, `done_o` at start+2. A `start_i` while busy is ignored, and `acc_cnt` is unchanged.
- `flush_i` after 3 of 6 accepts → valids clear next cycle, no `done_o`, IDLE. A new `start_i` then runs cleanly.
- `rsn_i` low mid-RUN → all outputs at reset values the following cycle. A fifth `op_valid_i` with `vl`=4 is never accepted.
